// File: rtl/spe_multi_neuron.sv
// Time-multiplexed spiking processing element: accumulates per-neuron partial sums,
// then integrates each neuron's previous potential and emits one result packet per neuron.
module spe_multi_neuron #(
    parameter int unsigned PE_ID       = 0,
    parameter int unsigned DEST_ADDR   = 0,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned OP_W        = 4,
    parameter int unsigned DATA_W      = 25,
    parameter int unsigned NUM_NEURONS = 4,
    parameter int unsigned IDX_W       = $clog2(NUM_NEURONS),
    parameter int unsigned VAL_W       = DATA_W - IDX_W - 1,
    parameter int unsigned THRESHOLD   = 64,
    parameter int unsigned TS_W        = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ADDR_W+OP_W+DATA_W-1:0] in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ADDR_W+OP_W+DATA_W-1:0] out_data,
    output logic [TS_W-1:0]               ts_count,
    output logic [3:0]                    err
);

    localparam int unsigned PKT_W = ADDR_W + OP_W + DATA_W;
    localparam int unsigned SUM_W = VAL_W + 1;
    localparam logic [VAL_W-1:0] VAL_MAX = '1;
    localparam logic [OP_W-1:0] OP_PSUM = OP_W'(0);
    localparam logic [OP_W-1:0] OP_TS_DONE = OP_W'(1);
    localparam logic [OP_W-1:0] OP_POT = OP_W'(2);
    localparam logic [OP_W-1:0] OP_RESULT = OP_W'(3);

    typedef enum logic [1:0] {
        ST_ACCUM    = 2'd0,
        ST_WAIT_POT = 2'd1,
        ST_EMIT     = 2'd2
    } state_t;

    state_t                 state;
    logic [VAL_W-1:0]       acc [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] done;

    logic [ADDR_W-1:0] pkt_addr;
    logic [OP_W-1:0]   pkt_op;
    logic [IDX_W-1:0]  pkt_idx;
    logic [VAL_W-1:0]  pkt_val;
    logic              unused_rsvd;
    logic              addr_ok;
    logic              idx_ok;
    logic              accept;
    logic [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]  over;
    logic [VAL_W-1:0]  psum_val;
    logic              psum_sat;
    logic              fire;
    logic [VAL_W-1:0]  residual;

    assign unused_rsvd = in_data[VAL_W];

    // Packet decode and the shared adder used by both psum accumulation and integration
    always_comb begin
        pkt_addr = in_data[PKT_W-1 -: ADDR_W];
        pkt_op   = in_data[DATA_W +: OP_W];
        pkt_idx  = in_data[DATA_W-1 -: IDX_W];
        pkt_val  = in_data[VAL_W-1:0];
        addr_ok  = (pkt_addr == ADDR_W'(PE_ID));
        idx_ok   = ({1'b0, pkt_idx} < (IDX_W+1)'(NUM_NEURONS));
        accept   = in_valid && in_ready;

        sum      = {1'b0, acc[pkt_idx]} + {1'b0, pkt_val};
        psum_sat = sum[VAL_W];
        psum_val = psum_sat ? VAL_MAX : sum[VAL_W-1:0];

        fire     = (sum >= SUM_W'(THRESHOLD));
        over     = sum - SUM_W'(THRESHOLD);
        if (fire) begin
            residual = over[VAL_W] ? VAL_MAX : over[VAL_W-1:0];
        end else begin
            residual = sum[VAL_W-1:0];
        end
    end

    // Control FSM with registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_ACCUM;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            ts_count  <= '0;
            err       <= '0;
            done      <= '0;
            for (int i = 0; i < int'(NUM_NEURONS); i++) begin
                acc[i] <= '0;
            end
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (accept) begin
                        if (!addr_ok) begin
                            err[0] <= 1'b1;
                        end else if (!idx_ok) begin
                            err[1] <= 1'b1;
                        end else if (pkt_op == OP_PSUM) begin
                            acc[pkt_idx] <= psum_val;
                            if (psum_sat) begin
                                err[3] <= 1'b1;
                            end
                        end else if (pkt_op == OP_TS_DONE) begin
                            state <= ST_WAIT_POT;
                        end else begin
                            err[1] <= 1'b1;
                        end
                    end
                end

                ST_WAIT_POT: begin
                    if (accept) begin
                        if (!addr_ok) begin
                            err[0] <= 1'b1;
                        end else if (!idx_ok) begin
                            err[1] <= 1'b1;
                        end else if (pkt_op != OP_POT) begin
                            err[1] <= 1'b1;
                        end else if (done[pkt_idx]) begin
                            err[2] <= 1'b1;
                        end else begin
                            out_data      <= {ADDR_W'(DEST_ADDR), OP_RESULT, pkt_idx, fire, residual};
                            out_valid     <= 1'b1;
                            in_ready      <= 1'b0;
                            done[pkt_idx] <= 1'b1;
                            state         <= ST_EMIT;
                        end
                    end
                end

                ST_EMIT: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        if (&done) begin
                            // Timestep complete: clear per-neuron state for the next one
                            done     <= '0;
                            ts_count <= ts_count + TS_W'(1);
                            state    <= ST_ACCUM;
                            for (int i = 0; i < int'(NUM_NEURONS); i++) begin
                                acc[i] <= '0;
                            end
                        end else begin
                            state <= ST_WAIT_POT;
                        end
                    end
                end

                default: begin
                    state     <= ST_ACCUM;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
